// File: rtl/pipeline_stall_ctrl.sv
// Hazard and stall controller for the five-stage MIPS pipeline: Tuse/Tnew register hazards plus MDU busy tracking.
// Optional build macro STALL_PERF_EN adds a 32-bit stalled-cycle counter on stall_cnt (tied to 0 otherwise).
module pipeline_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic        d_is_md,
    input  logic [4:0]  e_wa,
    input  logic [1:0]  e_tnew,
    input  logic [4:0]  m_wa,
    input  logic [1:0]  m_tnew,
    input  logic [1:0]  e_md_start,
    output logic        en_pc,
    output logic        en_fd,
    output logic        flush_de,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    localparam logic [1:0] MD_START_MULT = 2'b01;
    localparam logic [1:0] MD_START_DIV  = 2'b10;
    localparam logic [3:0] MULT_LOAD     = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD      = 4'(DIV_CYCLES);

    logic [3:0] md_cnt;
    logic       md_idle;
    logic       start_mult;
    logic       start_div;
    logic       hazard_rs;
    logic       hazard_rt;
    logic       stall_md;
    logic       stall;

    // A producer only blocks D if it writes a real register that D reads before the result is forwardable.
    function automatic logic reg_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] wa,
        input logic [1:0] tnew
    );
        return (src == wa) && (wa != 5'd0) && (tuse < tnew);
    endfunction

    assign md_idle    = (md_cnt == 4'd0);
    assign start_mult = (e_md_start == MD_START_MULT);
    assign start_div  = (e_md_start == MD_START_DIV);

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        hazard_rs = reg_hazard(d_rs, d_tuse_rs, e_wa, e_tnew)
                  | reg_hazard(d_rs, d_tuse_rs, m_wa, m_tnew);
        hazard_rt = reg_hazard(d_rt, d_tuse_rt, e_wa, e_tnew)
                  | reg_hazard(d_rt, d_tuse_rt, m_wa, m_tnew);
        md_busy   = ~reset & (~md_idle | start_mult | start_div);
        stall_md  = d_is_md & md_busy;
        stall     = ~reset & (hazard_rs | hazard_rt | stall_md);
    end

    assign en_pc    = ~stall;
    assign en_fd    = ~stall;
    assign flush_de = stall;

    // NOTE: state registers use non-blocking assignments and a synchronous reset sampled only at the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= 4'd0;
        end else if (md_idle && start_mult) begin
            md_cnt <= MULT_LOAD;
        end else if (md_idle && start_div) begin
            md_cnt <= DIV_LOAD;
        end else if (!md_idle) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

`ifdef STALL_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios plus random traffic against a cycle-indexed model.
module tb_pipeline_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  d_rs = '0, d_rt = '0, e_wa = '0, m_wa = '0;
    logic [1:0]  d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, e_tnew = '0, m_tnew = '0, e_md_start = '0;
    logic        d_is_md = 1'b0;
    logic        en_pc, en_fd, flush_de, md_busy;
    logic [31:0] stall_cnt;

    pipeline_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_is_md(d_is_md), .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa), .m_tnew(m_tnew),
        .e_md_start(e_md_start), .en_pc(en_pc), .en_fd(en_fd), .flush_de(flush_de),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    // Model: the MDU is free from cycle index md_free onward; stalls are counted as plain integers.
    int          cyc = 0;
    int          md_free = 0;
    logic [31:0] exp_cnt = '0;
    logic        exp_stall, exp_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, check outputs, then advance the model past the next rising edge.
    task automatic run_cycle(
        input logic rst, input logic [4:0] rs, input logic [1:0] tu_rs,
        input logic [4:0] rt, input logic [1:0] tu_rt, input logic md,
        input logic [4:0] ewa, input logic [1:0] etn,
        input logic [4:0] mwa, input logic [1:0] mtn, input logic [1:0] start
    );
        logic [4:0] src [2];
        logic [1:0] tuse [2];
        logic [4:0] dst [2];
        logic [1:0] tnew [2];
        logic       reg_haz, start_ok, idle;
        @(negedge clk);
        reset = rst; d_rs = rs; d_tuse_rs = tu_rs; d_rt = rt; d_tuse_rt = tu_rt;
        d_is_md = md; e_wa = ewa; e_tnew = etn; m_wa = mwa; m_tnew = mtn; e_md_start = start;
        #1;
        src[0] = rs; src[1] = rt; tuse[0] = tu_rs; tuse[1] = tu_rt;
        dst[0] = ewa; dst[1] = mwa; tnew[0] = etn; tnew[1] = mtn;
        reg_haz = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int p = 0; p < 2; p++)
                if (src[s] != 0 && src[s] == dst[p] && int'(tuse[s]) < int'(tnew[p]))
                    reg_haz = 1'b1;
        start_ok  = (start == 2'b01) || (start == 2'b10);
        idle      = (cyc >= md_free);
        exp_busy  = !rst && (!idle || start_ok);
        exp_stall = !rst && (reg_haz || (md && exp_busy));
        check("en_pc", {31'd0, en_pc}, {31'd0, !exp_stall});
        check("en_fd", {31'd0, en_fd}, {31'd0, !exp_stall});
        check("flush_de", {31'd0, flush_de}, {31'd0, exp_stall});
        check("md_busy", {31'd0, md_busy}, {31'd0, exp_busy});
        check("stall_cnt", stall_cnt, exp_cnt);
        if (rst) begin
            md_free = cyc + 1;
            exp_cnt = '0;
        end else begin
            if (start_ok && idle) md_free = cyc + 1 + ((start == 2'b01) ? MULT_N : DIV_N);
`ifdef STALL_PERF_EN
            if (exp_stall) exp_cnt = exp_cnt + 32'd1;
`endif
        end
        cyc++;
    endtask

    task automatic idle_cycle(input logic rst);
        run_cycle(rst, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        idle_cycle(1'b1);
        check("reset_en_pc", {31'd0, en_pc}, 32'd1);
        check("reset_flush", {31'd0, flush_de}, 32'd0);
        idle_cycle(1'b0);
        check("reset_cnt", stall_cnt, 32'd0);

        // Load-use with e_tnew 2 and 1, then $0 and no-use cases.
        run_cycle(1'b0, 5'd8, 2'd0, 5'd0, 2'd3, 1'b0, 5'd8, 2'd2, 5'd0, 2'd0, 2'b00);
        check("loaduse_t2", {31'd0, flush_de}, 32'd1);
        run_cycle(1'b0, 5'd8, 2'd0, 5'd0, 2'd3, 1'b0, 5'd8, 2'd1, 5'd0, 2'd0, 2'b00);
        check("loaduse_t1", {31'd0, en_pc}, 32'd0);
        run_cycle(1'b0, 5'd0, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd2, 5'd0, 2'd0, 2'b00);
        check("reg0_nostall", {31'd0, en_pc}, 32'd1);
        run_cycle(1'b0, 5'd8, 2'd3, 5'd0, 2'd3, 1'b0, 5'd8, 2'd2, 5'd0, 2'd0, 2'b00);
        check("nouse_nostall", {31'd0, flush_de}, 32'd0);
        run_cycle(1'b0, 5'd0, 2'd3, 5'd9, 2'd1, 1'b0, 5'd0, 2'd0, 5'd9, 2'd2, 2'b00);
        check("m_hazard_rt", {31'd0, flush_de}, 32'd1);
        idle_cycle(1'b0);
`ifdef STALL_PERF_EN
        check("perf_loaduse3", stall_cnt, 32'd3);
`else
        check("perf_off", stall_cnt, 32'd0);
`endif

        // Mult: MD instruction in D stalls cycles 0..5, proceeds at 6.
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0,
                      (i == 0) ? 2'b01 : 2'b00);
            check("mult_stall", {31'd0, flush_de}, (i <= 5) ? 32'd1 : 32'd0);
        end
        idle_cycle(1'b0);
`ifdef STALL_PERF_EN
        check("perf_total", stall_cnt, 32'd9);
`else
        check("perf_off2", stall_cnt, 32'd0);
`endif

        // Div with a non-MD instruction in D: busy for start plus 10, never stalled.
        for (int i = 0; i < 13; i++) begin
            run_cycle(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0,
                      (i == 0) ? 2'b10 : 2'b00);
            check("div_busy", {31'd0, md_busy}, (i <= 10) ? 32'd1 : 32'd0);
            check("div_nostall", {31'd0, en_pc}, 32'd1);
        end

        // Reset mid-div while md_cnt = 6, then an MD instruction proceeds.
        for (int i = 0; i < 5; i++)
            run_cycle(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0,
                      (i == 0) ? 2'b10 : 2'b00);
        idle_cycle(1'b1);
        run_cycle(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 2'b00);
        check("rst_div_busy", {31'd0, md_busy}, 32'd0);
        check("rst_div_md_go", {31'd0, en_fd}, 32'd1);

        // Random traffic over a small register set so hazards and $0 cases are frequent.
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] regs [4];
            logic [1:0] st;
            regs[0] = 5'd0; regs[1] = 5'd8; regs[2] = 5'd9; regs[3] = 5'd31;
            st = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_cycle($urandom_range(0, 60) == 0,
                      regs[$urandom_range(0, 3)], 2'($urandom_range(0, 3)),
                      regs[$urandom_range(0, 3)], 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)),
                      regs[$urandom_range(0, 3)], 2'($urandom_range(0, 3)),
                      regs[$urandom_range(0, 3)], 2'($urandom_range(0, 3)), st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
